// File: rtl/collision_scanner.sv
// Snapshots every snake on start, then scans one target segment per cycle against all
// live heads; per-snake hits collect into an accumulator that feeds sticky stop flags.
module collision_scanner #(
    parameter int NUM_SNAKES = 2,
    parameter int MAX_LEN    = 16,
    parameter int X_W        = 5,
    parameter int Y_W        = 5,
    parameter int LEN_BITS   = 5,
    parameter int GRID_W     = 32,
    parameter int GRID_H     = 24,
    parameter int SELF_CHECK = 1
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       start,
    input  logic                                       clear,
    input  logic [NUM_SNAKES*MAX_LEN*(X_W+Y_W)-1:0]    snakes,
    input  logic [NUM_SNAKES*LEN_BITS-1:0]             lens,
    output logic                                       busy,
    output logic                                       done,
    output logic [NUM_SNAKES-1:0]                      stop,
    output logic [NUM_SNAKES-1:0]                      hit_now
);

    localparam int NUM_LEN = X_W + Y_W;
    localparam int J_W     = (NUM_SNAKES > 1) ? $clog2(NUM_SNAKES) : 1;
    localparam int K_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCAN    = 2'd1,
        DONE_ST = 2'd2
    } state_t;

    state_t                              state_r, state_s;
    logic [NUM_SNAKES*MAX_LEN*NUM_LEN-1:0] snap_r;
    logic [NUM_SNAKES*LEN_BITS-1:0]      lens_r;
    logic [J_W-1:0]                      j_r, j_s;
    logic [K_W-1:0]                      k_r, k_s;
    logic [NUM_SNAKES-1:0]               acc_r, acc_s, hit_s;
    logic [NUM_LEN-1:0]                  tgt_seg_s;
    int                                  tgt_len_s;
    logic                                tgt_valid_s, first_s, last_s;

    function automatic int eff_len(input logic [LEN_BITS-1:0] l);
        return (int'(l) > MAX_LEN) ? MAX_LEN : int'(l);
    endfunction

    function automatic logic wall_hit(input logic [NUM_LEN-1:0] seg);
        return (int'(seg[X_W-1:0]) >= GRID_W) || (int'(seg[NUM_LEN-1:X_W]) >= GRID_H);
    endfunction

    // Compare the current snapshot target against every live head in parallel.
    always_comb begin
        hit_s       = {NUM_SNAKES{1'b0}};
        tgt_len_s   = eff_len(lens_r[int'(j_r)*LEN_BITS +: LEN_BITS]);
        tgt_seg_s   = snap_r[(int'(j_r)*MAX_LEN + int'(k_r))*NUM_LEN +: NUM_LEN];
        // A zero-length target snake makes every k invalid here.
        tgt_valid_s = (int'(k_r) < tgt_len_s);
        first_s     = (j_r == {J_W{1'b0}}) && (k_r == {K_W{1'b0}});
        for (int i = 0; i < NUM_SNAKES; i++) begin
            hit_s[i] = (eff_len(lens_r[i*LEN_BITS +: LEN_BITS]) != 0) &&
                       ((first_s && wall_hit(snap_r[i*MAX_LEN*NUM_LEN +: NUM_LEN])) ||
                        (tgt_valid_s &&
                         (snap_r[i*MAX_LEN*NUM_LEN +: NUM_LEN] == tgt_seg_s) &&
                         ((i != int'(j_r)) ||
                          ((k_r != {K_W{1'b0}}) && (SELF_CHECK != 0)))));
        end
    end

    // Next-state, counter stepping and accumulation.
    always_comb begin
        state_s = state_r;
        j_s     = j_r;
        k_s     = k_r;
        acc_s   = acc_r;
        last_s  = (int'(j_r) == NUM_SNAKES - 1) && (int'(k_r) == MAX_LEN - 1);
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = SCAN;
                    j_s     = {J_W{1'b0}};
                    k_s     = {K_W{1'b0}};
                    acc_s   = {NUM_SNAKES{1'b0}};
                end else begin
                    state_s = IDLE;
                end
            end
            SCAN: begin
                acc_s = acc_r | hit_s;
                if (last_s) begin
                    state_s = DONE_ST;
                end else if (int'(k_r) == MAX_LEN - 1) begin
                    k_s = {K_W{1'b0}};
                    j_s = j_r + J_W'(1'b1);
                end else begin
                    k_s = k_r + K_W'(1'b1);
                end
            end
            DONE_ST: state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, counters, accumulator and the input snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            j_r     <= {J_W{1'b0}};
            k_r     <= {K_W{1'b0}};
            acc_r   <= {NUM_SNAKES{1'b0}};
            snap_r  <= {(NUM_SNAKES*MAX_LEN*NUM_LEN){1'b0}};
            lens_r  <= {(NUM_SNAKES*LEN_BITS){1'b0}};
        end else begin
            state_r <= state_s;
            j_r     <= j_s;
            k_r     <= k_s;
            acc_r   <= acc_s;
            if ((state_r == IDLE) && start) begin
                snap_r <= snakes;
                lens_r <= lens;
            end
        end
    end

    // Registered outputs; the DONE update takes priority over clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            stop    <= {NUM_SNAKES{1'b0}};
            hit_now <= {NUM_SNAKES{1'b0}};
        end else begin
            busy <= (state_s == SCAN);
            done <= (state_s == DONE_ST);
            if (state_r == DONE_ST) begin
                hit_now <= acc_r;
                stop    <= clear ? acc_r : (stop | acc_r);
            end else if (clear) begin
                stop <= {NUM_SNAKES{1'b0}};
            end
        end
    end

endmodule
